// File: rtl/rsa_pkg.sv
// -----------------------------------------------------------------------------
// rsa_pkg
// Shared definitions for the RSA arithmetic blocks (montgomery_product,
// modulo_product and the exponentiation controller).
//   RSA_WIDTH    : default operand / modulus bit width
//   mont_state_t : FSM state encoding for the Montgomery product engine
// -----------------------------------------------------------------------------
package rsa_pkg;

    localparam int RSA_WIDTH = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mont_state_t;

endpackage : rsa_pkg

// File: rtl/mont_step.sv
// -----------------------------------------------------------------------------
// mont_step
// One bit-serial Montgomery iteration, purely combinational:
//   acc_next = (acc + a_bit*b + q*N) >> 1,  where q makes the sum even.
// Ports:
//   acc      in  [WIDTH+1:0] current accumulator
//   b        in  [WIDTH-1:0] multiplicand
//   N        in  [WIDTH-1:0] odd modulus
//   a_bit    in  1           current multiplier bit
//   acc_next out [WIDTH+1:0] accumulator after this iteration
// -----------------------------------------------------------------------------
module mont_step
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic [WIDTH+1:0] acc,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] N,
    input  logic             a_bit,
    output logic [WIDTH+1:0] acc_next
);

    logic [WIDTH+1:0] sum_b;
    logic [WIDTH+1:0] sum_n;

    // The accumulator stays below 2N between iterations, so acc + b + N fits
    // in WIDTH+2 bits and no carry is lost.
    always_comb begin
        sum_b    = acc + (a_bit ? {2'b00, b} : '0);
        // N is odd, so adding it to an odd sum makes the sum even and the
        // following shift is an exact division by two.
        sum_n    = sum_b + (sum_b[0] ? {2'b00, N} : '0);
        acc_next = sum_n >> 1;
    end

endmodule : mont_step

// File: rtl/montgomery_product.sv
// -----------------------------------------------------------------------------
// montgomery_product
// Bit-serial Montgomery multiplier: m = a * b * 2^-WIDTH mod N.
// One multiplier bit is consumed per CALC cycle, followed by a single final
// conditional subtraction in FIX. The result is valid while finish pulses.
// Ports:
//   clk     in  1          clock, all state changes on the rising edge
//   rst_n   in  1          synchronous active-low reset
//   start   in  1          request a product (only looked at in IDLE)
//   N       in  [WIDTH-1]  odd modulus, captured on start
//   a       in  [WIDTH-1]  multiplier, captured on start, a < N
//   b       in  [WIDTH-1]  multiplicand, captured on start, b < N
//   m       out [WIDTH-1]  registered result, updated only at the end of FIX
//   finish  out 1          registered one-cycle result-valid pulse
// -----------------------------------------------------------------------------
module montgomery_product
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] N,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] m,
    output logic             finish
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mont_state_t      state_q;
    mont_state_t      state_d;

    logic [WIDTH-1:0] n_q;
    logic [WIDTH-1:0] a_q;       // shifted right each CALC cycle; bit 0 is a[i]
    logic [WIDTH-1:0] b_q;
    logic [WIDTH+1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH+1:0] acc_step;
    logic [WIDTH+1:0] fix_diff;
    logic [WIDTH-1:0] m_d;

    logic             capture;
    logic             step_en;
    logic             load_m;
    logic             finish_d;

    mont_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc      (acc_q),
        .b        (b_q),
        .N        (n_q),
        .a_bit    (a_q[0]),
        .acc_next (acc_step)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: the default assignment at the top keeps this block free of
    // inferred latches when a case arm does not assign state_d.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start)             state_d = ST_CALC;
            ST_CALC: if (cnt_q == CNT_LAST) state_d = ST_FIX;
            ST_FIX:                         state_d = ST_DONE;
            ST_DONE:                        state_d = ST_IDLE;
            default:                        state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        capture  = 1'b0;
        step_en  = 1'b0;
        load_m   = 1'b0;
        finish_d = 1'b0;
        unique case (state_q)
            ST_IDLE: capture = start;
            ST_CALC: step_en = 1'b1;
            // m and finish are loaded on the FIX->DONE edge, so they are
            // both visible during the DONE cycle.
            ST_FIX: begin
                load_m   = 1'b1;
                finish_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Final reduction: acc < 2N, so one conditional subtraction suffices.
    // acc == N must reduce to 0, hence >= rather than >.
    always_comb begin
        fix_diff = acc_q - {2'b00, n_q};
        m_d      = (acc_q >= {2'b00, n_q}) ? fix_diff[WIDTH-1:0] : acc_q[WIDTH-1:0];
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // NOTE: the captured operands are cleared on reset as well, so an
    // aborted operation leaves no stale modulus or operands behind.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_q    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            m      <= '0;
            finish <= 1'b0;
        end else begin
            finish <= finish_d;
            if (capture) begin
                n_q   <= N;
                a_q   <= a;
                b_q   <= b;
                acc_q <= '0;
                cnt_q <= '0;
            end
            if (step_en) begin
                acc_q <= acc_step;
                a_q   <= a_q >> 1;
                cnt_q <= cnt_q + 1'b1;
            end
            if (load_m) begin
                m <= m_d;
            end
        end
    end

endmodule : montgomery_product

// File: doc/montgomery_product.md
MONTGOMERY_PRODUCT -- requirements
Module: montgomery_product

Interface
REQ-001 The block SHALL expose exactly one parameter: WIDTH, default 256, operand and modulus bit width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port start, input, 1 bit: request a product, sampled only in IDLE.
REQ-005 The block SHALL have port N, input, WIDTH bits: odd modulus, captured on start.
REQ-006 The block SHALL have port a, input, WIDTH bits: multiplier, captured on start, a < N.
REQ-007 The block SHALL have port b, input, WIDTH bits: multiplicand, captured on start, b < N.
REQ-008 The block SHALL have port m, output, WIDTH bits, registered: result a*b*2^-WIDTH mod N.
REQ-009 The block SHALL have port finish, output, 1 bit, registered: one-cycle result-valid pulse.

Function
REQ-010 The block SHALL implement a four-state FSM: IDLE, CALC, FIX, DONE.
REQ-011 In IDLE with start=1, the block SHALL, at the same edge:
- latch N, a and b;
- clear the accumulator and iteration counter;
- enter CALC.
REQ-012 In IDLE with start=0, the block SHALL hold all registers.
REQ-013 In CALC, iteration i (0..WIDTH-1) SHALL perform the following in one cycle:
- acc += b if a[i]=1;
- then acc += N if acc is odd;
- then acc >>= 1.
REQ-014 The accumulator SHALL be WIDTH+2 bits wide, so that acc+b+N never overflows.
REQ-015 The iteration counter SHALL be clog2(WIDTH)+1 bits wide.
REQ-016 The block SHALL leave CALC for FIX after exactly WIDTH iterations (counter = WIDTH-1 on the last one).
REQ-017 In FIX, m SHALL be loaded with acc-N if acc >= N, and with acc otherwise; the comparison SHALL be >= (acc = N gives 0).
REQ-018 The block SHALL move from FIX to DONE after one cycle.
REQ-019 In DONE, finish SHALL be 1 for exactly one cycle, after which the FSM returns to IDLE.
REQ-020 Latency: if start is sampled high at the edge ending cycle 0, then:
- CALC SHALL occupy cycles 1..WIDTH;
- FIX SHALL occupy cycle WIDTH+1;
- finish SHALL be 1 in cycle WIDTH+2 (258 for WIDTH=256).
REQ-021 m SHALL hold its value from the FIX load until the next FIX load; it SHALL NOT change in IDLE, CALC or DONE.
REQ-022 start asserted in CALC, FIX or DONE SHALL be ignored.
REQ-023 A back-to-back start in the IDLE cycle right after DONE SHALL be accepted.
REQ-024 Changes on N, a or b after capture SHALL NOT affect the running operation.
REQ-025 Behaviour for even N or for operands >= N is undefined; no error output exists.

Reset
REQ-026 While rst_n=0 at a rising edge, the block SHALL:
- set the state to IDLE;
- set m = 0 and finish = 0;
- clear the accumulator, counter and captured operands.
REQ-027 Reset asserted mid-operation SHALL abort the operation:
- no finish pulse;
- m = 0;
- a start in the first cycle after release SHALL be accepted normally.

Structure
REQ-028 A shared package rsa_pkg SHALL hold the WIDTH default constant and the FSM state enum, for use with the companion modulo_product and the exponentiation controller.
REQ-029 One combinational sub-module, mont_step, SHALL implement a single iteration:
- inputs: acc, b, N, a_bit;
- output: next acc;
- instantiated once, used every CALC cycle.

Verification (WIDTH=256; 2^256 mod 13 = 3; its inverse mod 13 = 9)
REQ-030 N=13, a=1, b=1, start one cycle -> finish=1 exactly 258 cycles later, m=9.
REQ-031 N=13, a=4, b=5 -> m=11; a=0, b=7 -> m=0; a=12, b=12 -> m=9.
REQ-032 Domain round trip: N=13, a=2 (5*2^256 mod 13), b=1 -> m=5.
REQ-033 Random odd 256-bit N with a, b < N (1000 runs) -> m equals the reference model a*b*2^-256 mod N; m < N always.
REQ-034 Protocol checks:
- start held high through a whole run -> second operation begins in the IDLE cycle after DONE;
- start pulsed in CALC -> ignored;
- a and b changed in CALC -> result unchanged.
REQ-035 rst_n low for one cycle at cycle 100 of a run -> no finish, m=0, state IDLE; a new start then completes correctly.
